// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the LEGv8 ALU.
//   - CONTROL opcode constants and the opcode_e enum used to decode them.
//   - Codes 0110/0111/1000 (shifts) are only decoded when ALU_SHIFT_EN is defined;
//     otherwise they fall into the "unlisted code" path like 1010..1111.
package alu_pkg;

    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] OP_AND   = 4'b0000;
    localparam logic [CTRL_W-1:0] OP_OR    = 4'b0001;
    localparam logic [CTRL_W-1:0] OP_ADD   = 4'b0010;
    localparam logic [CTRL_W-1:0] OP_SUB   = 4'b0011;
    localparam logic [CTRL_W-1:0] OP_XOR   = 4'b0100;
    localparam logic [CTRL_W-1:0] OP_NOR   = 4'b0101;
    localparam logic [CTRL_W-1:0] OP_SLL   = 4'b0110;
    localparam logic [CTRL_W-1:0] OP_SRL   = 4'b0111;
    localparam logic [CTRL_W-1:0] OP_SRA   = 4'b1000;
    localparam logic [CTRL_W-1:0] OP_PASSB = 4'b1001;

    typedef enum logic [CTRL_W-1:0] {
        OpAnd   = OP_AND,
        OpOr    = OP_OR,
        OpAdd   = OP_ADD,
        OpSub   = OP_SUB,
        OpXor   = OP_XOR,
        OpNor   = OP_NOR,
        OpSll   = OP_SLL,
        OpSrl   = OP_SRL,
        OpSra   = OP_SRA,
        OpPassB = OP_PASSB
    } opcode_e;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder/subtractor with flags.
//   a, b   : operands
//   sub    : 1 -> a - b computed as a + ~b + 1, 0 -> a + b
//   sum    : result modulo 2^WIDTH
//   carry  : carry-out (not-borrow when subtracting)
//   ovf    : signed overflow
module alu_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = full[WIDTH-1:0];
        carry = full[WIDTH];
        // Overflow: operand signs agree but the result sign differs.
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/legv8_alu.sv
// legv8_alu: single-cycle-latency registered LEGv8 ALU.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : a, b and control are qualified this cycle
//   a, b      : operands (b[4:0] is the shift amount)
//   control   : opcode (see alu_pkg)
//   result    : registered result
//   zeroflag, negflag, carryflag, ovfflag : registered flags
//   out_valid : result/flags were loaded by the most recent edge
// Config macro ALU_SHIFT_EN: builds SLL/SRL/SRA; without it those codes act as
// unlisted codes (result 0) and no shifter exists.
module legv8_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] control,
    output logic [WIDTH-1:0]  result,
    output logic              zeroflag,
    output logic              negflag,
    output logic              carryflag,
    output logic              ovfflag,
    output logic              out_valid
);

    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             zero_q, valid_q;

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a    (a),
        .b    (b),
        .sub  (control == OP_SUB),
        .sum  (as_sum),
        .carry(as_carry),
        .ovf  (as_ovf)
    );

`ifdef ALU_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = b[4:0];
`endif

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (control)
            OpAnd:   result_d = a & b;
            OpOr:    result_d = a | b;
            OpAdd, OpSub: begin
                result_d = as_sum;
                carry_d  = as_carry;
                ovf_d    = as_ovf;
            end
            OpXor:   result_d = a ^ b;
            OpNor:   result_d = ~(a | b);
`ifdef ALU_SHIFT_EN
            OpSll:   result_d = a << shamt;
            OpSrl:   result_d = a >> shamt;
            OpSra:   result_d = $unsigned($signed(a) >>> shamt);
`endif
            OpPassB: result_d = b;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (in_valid) begin
            result_q <= result_d;
            zero_q   <= (result_d == '0);
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            valid_q  <= 1'b1;
        end else begin
            // Idle cycle: hold result/flags, drop valid.
            valid_q  <= 1'b0;
        end
    end

    assign result    = result_q;
    assign zeroflag  = zero_q;
    assign negflag   = result_q[WIDTH-1];
    assign carryflag = carry_q;
    assign ovfflag   = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_legv8_alu.sv
// tb_legv8_alu: table-driven self-checking bench for legv8_alu.
// Shift expectations follow ALU_SHIFT_EN so the bench matches either build.
module tb_legv8_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a, b;
    logic [3:0]  control;
    logic [31:0] result;
    logic        zeroflag, negflag, carryflag, ovfflag, out_valid;

    int checks   = 0;
    int failures = 0;

    legv8_alu #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .control  (control),
        .result   (result),
        .zeroflag (zeroflag),
        .negflag  (negflag),
        .carryflag(carryflag),
        .ovfflag  (ovfflag),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input string nm, input logic [3:0] ctl,
                                    input logic [31:0] va, input logic [31:0] vb,
                                    input logic [31:0] res, input logic z, input logic n,
                                    input logic c, input logic v);
        vec_t t;
        t.name = nm; t.ctl = ctl; t.a = va; t.b = vb;
        t.res = res; t.z = z; t.n = n; t.c = c; t.v = v;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] res, input logic z,
                           input logic n, input logic c, input logic v, input logic ov);
        chk({nm, ".result"}, result, res);
        chk({nm, ".zero"}, {31'd0, zeroflag}, {31'd0, z});
        chk({nm, ".neg"}, {31'd0, negflag}, {31'd0, n});
        chk({nm, ".carry"}, {31'd0, carryflag}, {31'd0, c});
        chk({nm, ".ovf"}, {31'd0, ovfflag}, {31'd0, v});
        chk({nm, ".valid"}, {31'd0, out_valid}, {31'd0, ov});
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic step(input logic r, input logic iv, input logic [3:0] ctl,
                        input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        rst = r; in_valid = iv; control = ctl; a = va; b = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //       name        ctl      a             b             result        z     n     c     v
        add_vec("add10_20",  4'b0010, 32'd10,       32'd20,       32'd30,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("sub30_10",  4'b0011, 32'd30,       32'd10,       32'd20,       1'b0, 1'b0, 1'b1, 1'b0);
        add_vec("sub5_5",    4'b0011, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1'b1, 1'b0);
        add_vec("and",       4'b0000, 32'h0000FFFF, 32'h0000F0F0, 32'h0000F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("or",        4'b0001, 32'h000000FF, 32'h0000FF00, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("xor",       4'b0100, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("add_ovf",   4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        add_vec("add_carry", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec("sub0_1",    4'b0011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec("sub_ovf",   4'b0011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        add_vec("nor",       4'b0101, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec("passb",     4'b1001, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("unlisted",  4'b1111, 32'h000000FF, 32'h000000FF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SHIFT_EN
        add_vec("sra",       4'b1000, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec("srl",       4'b0111, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("sll_b40",   4'b0110, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec("srl_by0",   4'b0111, 32'h0000ABCD, 32'h00000020, 32'h0000ABCD, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        add_vec("sra",       4'b1000, 32'h80000000, 32'd4,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("srl",       4'b0111, 32'h80000000, 32'd4,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec("sll",       4'b0110, 32'h00000001, 32'h00000024, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Reset with a valid op presented: op is discarded.
        rst = 1'b1; in_valid = 1'b1; control = 4'b0010; a = 32'd3; b = 32'd4;
        step(1'b1, 1'b1, 4'b0010, 32'd3, 32'd4);
        step(1'b1, 1'b1, 4'b1001, 32'd0, 32'h55);
        chk_all("reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // First edge with rst=0 accepts the first vector; vectors run back to back.
        foreach (vecs[i]) begin
            step(1'b0, 1'b1, vecs[i].ctl, vecs[i].a, vecs[i].b);
            chk_all(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v,
                    1'b1);
        end

        // Idle cycle: valid drops, result and flags hold (sub_ovf values).
        step(1'b0, 1'b1, 4'b0011, 32'h80000000, 32'h00000001);
        step(1'b0, 1'b0, 4'b0010, 32'h11111111, 32'h22222222);
        chk_all("hold", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Mid-stream reset with in_valid=1.
        step(1'b0, 1'b1, 4'b0010, 32'h7FFFFFFF, 32'h1);
        step(1'b1, 1'b1, 4'b0010, 32'd1, 32'd1);
        chk_all("midrst", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back after reset release.
        step(1'b0, 1'b1, 4'b0010, 32'd2, 32'd3);
        chk_all("b2b_add", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'b0011, 32'd3, 32'd5);
        chk_all("b2b_sub", 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'b0000, 32'hF0F0F0F0, 32'h0F0F0F0F);
        chk_all("b2b_and", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/legv8_alu.md
LEGV8_ALU -- requirements
Module: legv8_alu

Interface
REQ-001 WIDTH, 32, datapath width in bits for A, B and RESULT.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 IN_VALID  input  1  operands and CONTROL qualified this cycle.
REQ-005 A  input  WIDTH  first operand.
REQ-006 B  input  WIDTH  second operand; shift amount is B[4:0].
REQ-007 CONTROL  input  4  operation select.
REQ-008 RESULT  output  WIDTH  registered operation result.
REQ-009 ZEROFLAG  output  1  registered; 1 when RESULT equals 0.
REQ-010 NEGFLAG  output  1  registered; equals RESULT[WIDTH-1].
REQ-011 CARRYFLAG  output  1  registered carry-out for ADD, not-borrow for SUB; 0 for other ops.
REQ-012 OVFFLAG  output  1  registered signed overflow for ADD/SUB; 0 for other ops.
REQ-013 OUT_VALID  output  1  RESULT and flags valid this cycle.

Function
REQ-014 CONTROL encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB (A-B), 0100 XOR, 0101 NOR, 0110 SLL, 0111 SRL, 1000 SRA, 1001 PASS_B (RESULT=B).
REQ-015 Unlisted CONTROL codes SHALL produce RESULT=0, ZEROFLAG=1, other flags 0.
REQ-016 Latency SHALL be exactly 1 cycle: operands sampled at edge N with IN_VALID=1 appear on RESULT/flags with OUT_VALID=1 after edge N.
REQ-017 With IN_VALID=0 at an edge, OUT_VALID SHALL go 0 and RESULT/flags SHALL hold previous values.
REQ-018 No backpressure; a new operation SHALL be accepted every cycle.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; SUB computed as A + ~B + 1.
REQ-020 OVFFLAG SHALL be 1 when operand signs (B inverted for SUB) agree and result sign differs.
REQ-021 Shifts SHALL use B[4:0] only; shift by 0 returns A; SRA replicates A[WIDTH-1].
REQ-022 ZEROFLAG SHALL be computed from the registered RESULT value for every op, including logic ops.

Reset
REQ-023 When rst=1 at an edge, RESULT=0, ZEROFLAG=1, NEGFLAG=0, CARRYFLAG=0, OVFFLAG=0, OUT_VALID=0.
REQ-024 rst SHALL take priority over IN_VALID; an operation presented during reset is discarded.
REQ-025 The first operation SHALL be accepted on the first edge with rst=0.

Configuration
REQ-026 Macro ALU_SHIFT_EN: when defined, SLL/SRL/SRA operate per REQ-021.
REQ-027 When ALU_SHIFT_EN is undefined, codes 0110/0111/1000 SHALL behave as unlisted codes (REQ-015) and no shifter logic is built.

Structure
REQ-028 Package alu_pkg SHALL hold the CONTROL opcode constants and an opcode enum typedef.
REQ-029 Add/sub with carry and overflow SHALL be a sub-module alu_addsub; all other logic stays in legv8_alu.

Verification
REQ-030 A=10, B=20, CONTROL=0010 -> next cycle RESULT=30, ZEROFLAG=0, OUT_VALID=1.
REQ-031 A=30, B=10, CONTROL=0011 -> RESULT=20, CARRYFLAG=1; A=5, B=5, SUB -> RESULT=0, ZEROFLAG=1.
REQ-032 AND FFFF&F0F0 -> F0F0; OR 00FF|FF00 -> FFFF; XOR FFFF^FFFF -> 0 with ZEROFLAG=1.
REQ-033 A=7FFFFFFF, B=1, ADD -> RESULT=80000000, OVFFLAG=1, NEGFLAG=1; A=FFFFFFFF, B=1, ADD -> 0, CARRYFLAG=1.
REQ-034 With ALU_SHIFT_EN: A=80000000, B=4, SRA -> F8000000; SRL -> 08000000; without macro, SRA -> 0.
REQ-035 rst=1 asserted mid-stream with IN_VALID=1 -> next cycle RESULT=0, ZEROFLAG=1, OUT_VALID=0; back-to-back valid ops afterwards produce results every cycle.
